// File: rtl/imem_responder.sv
// Instruction-memory responder: loads a program over a valid/ready stream,
// then serves the fetch stage with a 1-cycle registered read and releases core_hold.
module imem_responder #(
  parameter int          DEPTH    = 128,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  IMaddra,
  output logic [31:0] IMdouta,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        run_go,
  output logic        core_hold,
  output logic [7:0]  ld_count,
  output logic        ld_overflow,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        ld_ready_q, ld_ready_d;
  logic        core_hold_q, core_hold_d;
  logic        xfer_s;
  logic        we_s;
  logic [31:0] mem_rd_s;

  assign mem_rd_s = mem[IMaddra];

  // Next-state, pointer, counters and read data.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    ovf_d       = ovf_q;
    fetch_cnt_d = fetch_cnt_q;
    dout_d      = NOP_WORD;
    we_s        = 1'b0;
    xfer_s      = ld_valid && ld_ready_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_s) begin
          we_s     = 1'b1;
          wr_ptr_d = 8'd1;
          state_d  = ld_last ? S_RUN : S_LOAD;
        end else if (run_go && !ld_valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (xfer_s) begin
          // The pointer stops at DEPTH; excess words only flag overflow.
          if (wr_ptr_q < DEPTH_C) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = ld_last ? S_RUN : S_LOAD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        dout_d = mem_rd_s;
        if (fetch_cnt_q != 16'hFFFF) begin
          fetch_cnt_d = fetch_cnt_q + 16'd1;
        end else begin
          fetch_cnt_d = fetch_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ld_ready_d  = (state_d != S_RUN);
    core_hold_d = (state_d != S_RUN);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= 8'd0;
      ovf_q       <= 1'b0;
      fetch_cnt_q <= 16'd0;
      dout_q      <= NOP_WORD;
      ld_ready_q  <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      ovf_q       <= ovf_d;
      fetch_cnt_q <= fetch_cnt_d;
      dout_q      <= dout_d;
      ld_ready_q  <= ld_ready_d;
      core_hold_q <= core_hold_d;
    end
  end

  // Program storage; deliberately not reset so run_go can reuse old contents.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem[wr_ptr_q[6:0]] <= ld_data;
    end
  end

  assign IMdouta     = dout_q;
  assign ld_ready    = ld_ready_q;
  assign core_hold   = core_hold_q;
  assign ld_count    = wr_ptr_q;
  assign ld_overflow = ovf_q;
  assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  IMaddra;
  logic [31:0] IMdouta;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        run_go;
  logic        core_hold;
  logic [7:0]  ld_count;
  logic        ld_overflow;
  logic [15:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  imem_responder dut (
    .clk(clk), .rst(rst), .IMaddra(IMaddra), .IMdouta(IMdouta),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .run_go(run_go), .core_hold(core_hold), .ld_count(ld_count),
    .ld_overflow(ld_overflow), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; run_go = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    IMaddra = a;
    tick();
    chk(tag, IMdouta, exp);
  endtask

  initial begin
    IMaddra = 7'd0; ld_data = 32'd0;
    do_reset();
    chk("rst_dout",  IMdouta, 32'h0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_hold",  {31'd0, core_hold}, 32'd1);
    chk("rst_cnt",   {24'd0, ld_count}, 32'd0);
    chk("rst_ovf",   {31'd0, ld_overflow}, 32'd0);
    chk("rst_fetch", {16'd0, fetch_count}, 32'd0);
    tick();
    chk("idle_ready", {31'd0, ld_ready}, 32'd1);

    // Basic 3-word load
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    chk("t1_load_dout", IMdouta, 32'h0);
    chk("t1_hold_before", {31'd0, core_hold}, 32'd1);
    send(32'hF800_0000, 1'b1);
    chk("t1_hold_after", {31'd0, core_hold}, 32'd0);
    chk("t1_ready_run", {31'd0, ld_ready}, 32'd0);
    chk("t1_cnt", {24'd0, ld_count}, 32'd3);
    rd("t1_rd2", 7'd2, 32'hF800_0000);
    rd("t1_rd0", 7'd0, 32'h1111_1111);
    chk("t1_fetch", {16'd0, fetch_count}, 32'd2);
    // Loader activity in RUN is ignored
    send(32'h5555_5555, 1'b1);
    chk("t1_run_ignore_cnt", {24'd0, ld_count}, 32'd3);
    rd("t1_rd0b", 7'd0, 32'h1111_1111);

    // 130-word overflow load
    do_reset();
    tick();
    for (int i = 1; i <= 130; i++) send(32'hA000_0000 + 32'(i), (i == 130) ? 1'b1 : 1'b0);
    chk("t2_cnt", {24'd0, ld_count}, 32'd128);
    chk("t2_ovf", {31'd0, ld_overflow}, 32'd1);
    chk("t2_hold", {31'd0, core_hold}, 32'd0);
    rd("t2_rd0", 7'd0, 32'hA000_0001);
    rd("t2_rd127", 7'd127, 32'hA000_0080);
    chk("t2_ovf_sticky", {31'd0, ld_overflow}, 32'd1);

    // Gapped loader stream
    do_reset();
    tick();
    send(32'hB000_0001, 1'b0);
    ld_data = 32'hDEAD_BEEF; tick(); tick();
    send(32'hB000_0002, 1'b0);
    send(32'hB000_0003, 1'b1);
    chk("t3_cnt", {24'd0, ld_count}, 32'd3);
    chk("t3_ovf_clr", {31'd0, ld_overflow}, 32'd0);
    rd("t3_rd0", 7'd0, 32'hB000_0001);
    rd("t3_rd1", 7'd1, 32'hB000_0002);
    rd("t3_rd2", 7'd2, 32'hB000_0003);
    rd("t3_rd3", 7'd3, 32'hA000_0004);

    // Reset during RUN, then run_go reuses memory
    do_reset();
    chk("t4_rst_hold", {31'd0, core_hold}, 32'd1);
    tick();
    run_go = 1'b1;
    tick();
    run_go = 1'b0;
    chk("t4_hold", {31'd0, core_hold}, 32'd0);
    chk("t4_fetch0", {16'd0, fetch_count}, 32'd0);
    chk("t4_cnt0", {24'd0, ld_count}, 32'd0);
    rd("t4_rd1", 7'd1, 32'hB000_0002);
    chk("t4_fetch1", {16'd0, fetch_count}, 32'd1);

    // Reset mid-load, then 1-word reload
    do_reset();
    tick();
    send(32'hC000_0001, 1'b0);
    send(32'hC000_0002, 1'b0);
    chk("t5_cnt2", {24'd0, ld_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cnt_rst", {24'd0, ld_count}, 32'd0);
    chk("t5_dout_rst", IMdouta, 32'h0);
    chk("t5_hold_rst", {31'd0, core_hold}, 32'd1);
    tick();
    send(32'hD000_0001, 1'b1);
    chk("t5_cnt1", {24'd0, ld_count}, 32'd1);
    rd("t5_rd0", 7'd0, 32'hD000_0001);
    rd("t5_rd1", 7'd1, 32'hC000_0002);
    rd("t5_rd2", 7'd2, 32'hB000_0003);

    // run_go together with ld_valid: load wins, run_go ignored in LOAD
    do_reset();
    tick();
    run_go = 1'b1;
    send(32'hE000_0001, 1'b0);
    chk("t6_hold", {31'd0, core_hold}, 32'd1);
    chk("t6_cnt", {24'd0, ld_count}, 32'd1);
    tick();
    chk("t6_go_ignored", {31'd0, core_hold}, 32'd1);
    run_go = 1'b0;
    send(32'hE000_0002, 1'b1);
    chk("t6_cnt2", {24'd0, ld_count}, 32'd2);
    rd("t6_rd0", 7'd0, 32'hE000_0001);
    rd("t6_rd1", 7'd1, 32'hE000_0002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's single read port (7-bit word address in, 32-bit instruction out) and owning program loading. After reset it accepts a program as a stream of 32-bit words over a valid/ready handshake, writes them sequentially from address 0, then releases the core to run. During run it returns the word at the requested address one clock later. It sits between the external program loader and the fetch stage, and drives the core's hold/reset request.

## Interface
- DEPTH, 128: instruction words; address width fixed at 7 bits.
- NOP_WORD, 32'h0000_0000: value driven on IMdouta outside RUN.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- IMaddra  in  7  word address from the fetch stage.
- IMdouta  out  32  instruction returned to the fetch stage.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks final word of the program; qualified by ld_valid.
- ld_ready  out  1  responder accepts ld_data this cycle.
- run_go  in  1  start running without loading; memory contents are retained.
- core_hold  out  1  high while the core must stay in reset (all states except RUN).
- ld_count  out  8  words written since the last load began; saturates at DEPTH.
- ld_overflow  out  1  sticky: a word arrived after DEPTH words were written.
- fetch_count  out  16  RUN-state reads; saturating.

## Operation
- States: IDLE, LOAD, RUN.
- Reset values: state=IDLE, IMdouta=NOP_WORD, ld_ready=0, core_hold=1, ld_count=0, ld_overflow=0, fetch_count=0, write pointer=0. Memory contents are not reset.
- IDLE: ld_ready=1. An ld_valid handshake moves the block to LOAD and writes the word in the same cycle (pointer 0). If that word also has ld_last, go directly to RUN. run_go without ld_valid goes to RUN. If both run_go and ld_valid are high, the load wins.
- LOAD: ld_ready=1. Each cycle with ld_valid=1 is a transfer. A transfer with pointer<DEPTH writes mem[pointer], increments the pointer, and increments ld_count. A transfer with pointer==DEPTH discards the word and sets ld_overflow. The pointer does not wrap. A transfer with ld_last moves the block to RUN on the next cycle. run_go is ignored.
- RUN: ld_ready=0 and core_hold=0. Each cycle IMdouta <= mem[IMaddra], and fetch_count increments, saturating at 16'hFFFF. Loader inputs are ignored. The block leaves RUN only via rst.
- In IDLE and LOAD, IMdouta is forced to NOP_WORD.
- A new load after reset restarts the pointer at 0 and clears ld_count and ld_overflow. Words beyond the new program keep their old contents.

## Timing
- Read latency is 1 cycle: IMaddra sampled at rising edge N appears on IMdouta after edge N. The fetch stage changes its address on the falling edge, so the address is stable at the rising edge.
- Write latency is 1 cycle. A word written at edge N is readable at edge N+1.
- The final-word handshake at edge N moves the state to RUN at edge N. core_hold falls after edge N. The first real read is sampled at edge N+1, which returns mem[0] when the core restarts at PC 0.
- rst high at any edge, including mid-load, forces the reset values at that edge. A partially loaded memory keeps the words already written.
- ld_ready is a function of state only; it has no combinational path from ld_valid.

## Test plan
- Reset, then load 3 words 0x11111111, 0x22222222, 0xF8000000 (last) -> ld_count=3, core_hold falls the cycle after the last handshake. IMaddra=2 -> IMdouta=0xF8000000 one cycle later.
- Load 130 words with ld_last on word 130 -> ld_count=128, ld_overflow=1, mem[0] still holds word 1 (no wrap). Enters RUN.
- Loader with gaps (ld_valid toggling 1,0,0,1,1 last) -> exactly 3 words written at addresses 0..2. No write occurs on idle cycles.
- After a load, assert rst during RUN, then run_go -> RUN with the old contents. IMaddra=1 returns the previously loaded word 1. fetch_count restarts at 0.
- Assert rst in LOAD after 2 of 5 words -> state=IDLE, ld_count=0, IMdouta=NOP_WORD. Reload 1 word (last) -> mem[0] is the new word and mem[1] still holds the old one.
- Hold run_go and ld_valid high together in IDLE -> LOAD is taken and the word is written at address 0.
